// File: rtl/mux16_scan_ctrl.sv
// mux16_scan_ctrl: serializes a 16-bit word through an external
// 16:1 bit-select mux, one framed bit per HOLD_CYC clock cycles.
module mux16_scan_ctrl #(
  parameter bit MSB_FIRST = 1'b0,
  parameter int HOLD_CYC  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        abort,
  output logic [15:0] mux_in,
  output logic [3:0]  mux_sel,
  input  logic        mux_out,
  output logic        ser_valid,
  output logic        ser_bit,
  output logic        ser_last,
  output logic        busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  localparam logic [3:0] START = MSB_FIRST ? 4'd15 : 4'd0;
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);

  logic [0:0] state;
  logic [7:0] hcnt;
  logic [3:0] idx;
  logic [3:0] sel_next;
  logic       accept;
  logic       sample;
  logic       final_bit;

  assign in_ready  = rst_n && (state == IDLE) && !abort;
  assign busy      = (state == SCAN);
  assign accept    = in_valid && in_ready;
  assign sample    = (hcnt == HOLD_LAST);
  assign final_bit = (idx == 4'd15);
  assign sel_next  = MSB_FIRST ? (mux_sel - 4'd1)
                               : (mux_sel + 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mux_in    <= '0;
      mux_sel   <= START;
      hcnt      <= '0;
      idx       <= '0;
      ser_valid <= 1'b0;
      ser_bit   <= 1'b0;
      ser_last  <= 1'b0;
    end else begin
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      unique case (1'b1)
        (state == IDLE): begin
          if (accept) begin
            mux_in  <= in_data;
            mux_sel <= START;
            hcnt    <= '0;
            idx     <= '0;
            state   <= SCAN;
          end
        end
        (state == SCAN): begin
          if (abort) begin
            state   <= IDLE;
            mux_sel <= START;
            hcnt    <= '0;
            idx     <= '0;
          end else if (sample) begin
            ser_bit   <= mux_out;
            ser_valid <= 1'b1;
            hcnt      <= '0;
            idx       <= idx + 4'd1;
            // last position returns to start instead of wrapping
            if (final_bit) begin
              ser_last <= 1'b1;
              state    <= IDLE;
              mux_sel  <= START;
            end else begin
              mux_sel <= sel_next;
            end
          end else begin
            hcnt <= hcnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// tb_mux16_scan_ctrl: three DUT configurations checked against a
// word-level model of bit order, timing and framing.
module tb_mux16_scan_ctrl;

  localparam int NDUT = 3;
  localparam int HC [NDUT] = '{1, 1, 3};
  localparam bit MS [NDUT] = '{1'b0, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid [NDUT];
  logic        in_ready [NDUT];
  logic [15:0] in_data [NDUT];
  logic        abort [NDUT];
  logic [15:0] mux_in [NDUT];
  logic [3:0]  mux_sel [NDUT];
  logic        mux_out [NDUT];
  logic        ser_valid [NDUT];
  logic        ser_bit [NDUT];
  logic        ser_last [NDUT];
  logic        busy [NDUT];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mux16_scan_ctrl #(
      .MSB_FIRST(MS[g]),
      .HOLD_CYC (HC[g])
    ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_data  (in_data[g]),
      .abort    (abort[g]),
      .mux_in   (mux_in[g]),
      .mux_sel  (mux_sel[g]),
      .mux_out  (mux_out[g]),
      .ser_valid(ser_valid[g]),
      .ser_bit  (ser_bit[g]),
      .ser_last (ser_last[g]),
      .busy     (busy[g])
    );
    // behavioural 16:1 mux
    assign mux_out[g] = mux_in[g][mux_sel[g]];
  end

  function automatic logic [3:0] pos(input int d, input int i);
    return MS[d] ? 4'(15 - i) : 4'(i);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scan word w on DUT d; stop>0 aborts after that many bits,
  // rst=1 pulses reset at that point instead.
  task automatic scan(input int d, input logic [15:0] w,
                      input logic [15:0] mid, input bit keep,
                      input int stop, input bit rst,
                      output int e0);
    int h;
    int n;
    int k;
    logic [23:0] exp_v;
    logic [23:0] obs_v;
    logic        v_e;
    logic        b_e;
    logic        l_e;
    logic        busy_e;
    logic [3:0]  sel_e;
    h = HC[d];
    n = (stop > 0) ? stop * h : 16 * h;
    checks++;
    if (in_ready[d] !== 1'b1) begin
      failures++;
      $display("FAIL ready_before_accept d=%0d got=%b exp=1",
               d, in_ready[d]);
    end
    in_valid[d] = 1'b1;
    in_data[d]  = w;
    step();
    e0 = cyc;
    for (int c = 0; c <= n; c++) begin
      if (c > 0) begin
        in_data[d]  = mid;
        in_valid[d] = keep ? 1'b1 : 1'($urandom_range(1));
        step();
      end
      k      = c / h;
      v_e    = (c > 0) && (c % h == 0);
      b_e    = v_e ? w[pos(d, k - 1)] : 1'b0;
      l_e    = v_e && (k == 16);
      busy_e = (c < 16 * h);
      sel_e  = busy_e ? pos(d, k) : pos(d, 0);
      exp_v  = {busy_e, v_e, l_e, b_e, sel_e, w};
      obs_v  = {busy[d], ser_valid[d], ser_last[d],
                ser_valid[d] & ser_bit[d], mux_sel[d], mux_in[d]};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL scan d=%0d w=%h c=%0d got=%h exp=%h",
                 d, w, c, obs_v, exp_v);
      end
    end
    in_valid[d] = keep;
    if (stop > 0 && !rst) begin
      abort[d] = 1'b1;
      #1;
      checks++;
      if (in_ready[d] !== 1'b0) begin
        failures++;
        $display("FAIL abort_ready_mask d=%0d got=%b exp=0",
                 d, in_ready[d]);
      end
      step();
      abort[d] = 1'b0;
      #1;
      exp_v = {1'b0, 1'b0, 1'b0, 1'b1, pos(d, 0), w};
      obs_v = {busy[d], ser_valid[d], ser_last[d], in_ready[d],
               mux_sel[d], mux_in[d]};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL abort_state d=%0d got=%h exp=%h",
                 d, obs_v, exp_v);
      end
      for (int i = 0; i < 2 * h + 1; i++) begin
        step();
        checks++;
        if ({busy[d], ser_valid[d], ser_last[d]} !== 3'b000) begin
          failures++;
          $display("FAIL post_abort d=%0d i=%0d got=%b exp=000",
                   d, i, {busy[d], ser_valid[d], ser_last[d]});
        end
      end
    end
    if (rst) begin
      #2;
      rst_n = 1'b0;
      #1;
      exp_v = {1'b0, 1'b0, 1'b0, 1'b0, pos(d, 0), 16'h0};
      obs_v = {busy[d], ser_valid[d], ser_last[d], in_ready[d],
               mux_sel[d], mux_in[d]};
      checks++;
      if (obs_v !== exp_v || ser_bit[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid_scan d=%0d got=%h/%b exp=%h/0",
                 d, obs_v, ser_bit[d], exp_v);
      end
      step();
      rst_n = 1'b1;
      step();
      checks++;
      if ({in_ready[d], busy[d]} !== 2'b10) begin
        failures++;
        $display("FAIL reset_release d=%0d got=%b exp=10",
                 d, {in_ready[d], busy[d]});
      end
    end
  endtask

  task automatic test_reset();
    logic [23:0] exp_v;
    logic [23:0] obs_v;
    for (int d = 0; d < NDUT; d++) begin
      in_valid[d] = 1'b0;
      in_data[d]  = '0;
      abort[d]    = 1'b0;
    end
    rst_n = 1'b0;
    step();
    step();
    for (int d = 0; d < NDUT; d++) begin
      exp_v = {1'b0, 1'b0, 1'b0, 1'b0, pos(d, 0), 16'h0};
      obs_v = {busy[d], ser_valid[d], ser_last[d], in_ready[d],
               mux_sel[d], mux_in[d]};
      checks++;
      if (obs_v !== exp_v || ser_bit[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_values d=%0d got=%h/%b exp=%h/0",
                 d, obs_v, ser_bit[d], exp_v);
      end
    end
    rst_n = 1'b1;
    step();
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if ({in_ready[d], busy[d]} !== 2'b10) begin
        failures++;
        $display("FAIL reset_release d=%0d got=%b exp=10",
                 d, {in_ready[d], busy[d]});
      end
    end
  endtask

  task automatic test_lsb_pattern();
    int e0;
    scan(0, 16'hA5C3, 16'(($urandom)), 1'b0, 0, 1'b0, e0);
    in_valid[0] = 1'b0;
    step();
  endtask

  task automatic test_msb_pattern();
    int e0;
    scan(1, 16'h8001, 16'hFFFE, 1'b0, 0, 1'b0, e0);
    in_valid[1] = 1'b0;
    step();
  endtask

  task automatic test_hold3();
    int e0;
    scan(2, 16'hFFFF, 16'h0000, 1'b0, 0, 1'b0, e0);
    in_valid[2] = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int e1;
    int e2;
    for (int d = 0; d < NDUT; d = d + 2) begin
      scan(d, 16'h1234, 16'h5678, 1'b1, 0, 1'b0, e1);
      scan(d, 16'h5678, 16'(($urandom)), 1'b0, 0, 1'b0, e2);
      checks++;
      if (e2 - e1 !== 16 * HC[d] + 1) begin
        failures++;
        $display("FAIL b2b_spacing d=%0d got=%0d exp=%0d",
                 d, e2 - e1, 16 * HC[d] + 1);
      end
      in_valid[d] = 1'b0;
      step();
    end
  endtask

  task automatic test_abort();
    int e0;
    for (int d = 0; d < NDUT; d++) begin
      scan(d, 16'($urandom), 16'($urandom), 1'b0, 7, 1'b0, e0);
      in_valid[d] = 1'b0;
    end
  endtask

  task automatic test_abort_idle();
    for (int d = 0; d < NDUT; d++) begin
      abort[d]    = 1'b1;
      in_valid[d] = 1'b1;
      in_data[d]  = 16'($urandom);
      #1;
      checks++;
      if (in_ready[d] !== 1'b0) begin
        failures++;
        $display("FAIL abort_idle_ready d=%0d got=%b exp=0",
                 d, in_ready[d]);
      end
      step();
      abort[d]    = 1'b0;
      in_valid[d] = 1'b0;
      #1;
      checks++;
      if ({busy[d], in_ready[d]} !== 2'b01) begin
        failures++;
        $display("FAIL abort_idle_state d=%0d got=%b exp=01",
                 d, {busy[d], in_ready[d]});
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    int e0;
    for (int d = 0; d < NDUT; d++) begin
      scan(d, 16'($urandom) | 16'h1, 16'($urandom), 1'b0,
           int'($urandom_range(3, 12)), 1'b1, e0);
      in_valid[d] = 1'b0;
    end
  endtask

  task automatic test_random();
    int e0;
    for (int r = 0; r < 4; r++) begin
      for (int d = 0; d < NDUT; d++) begin
        scan(d, 16'($urandom), 16'($urandom), 1'b0, 0, 1'b0, e0);
        in_valid[d] = 1'b0;
        step();
      end
    end
  endtask

  initial begin
    test_reset();
    test_lsb_pattern();
    test_msb_pattern();
    test_hold3();
    test_back_to_back();
    test_abort();
    test_abort_idle();
    test_reset_mid_scan();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
